// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: state encodings shared by the hazard sequencer and its users
package pipe_hazard_ctrl_pkg;
   localparam int ST_W = 2;
   localparam logic [ST_W-1:0] ST_RUN      = 2'd0;
   localparam logic [ST_W-1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [ST_W-1:0] ST_TIMEOUT  = 2'd2;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: sync-reset up counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt <= '0;
      else if (inc && cnt != '1) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipe (load-use, MEM branch, memory wait)
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             mem_branch_taken_i,
   input  logic             mem_access_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             pipe_hold_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_flush_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [1:0]       state_o
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   logic [ST_W-1:0] state;
   logic [WW-1:0]   wait_cnt;
   logic st_wait, st_to, frozen, load_use, branch, bubble;
   always_comb begin
      st_wait  = state == ST_MEM_WAIT;
      st_to    = state == ST_TIMEOUT;
      // in MEM_WAIT only mem_ready_i matters; in RUN the MEM stage must actually be accessing
      frozen   = !rst_i && (st_to || (!mem_ready_i && (st_wait || mem_access_i)));
      load_use = ex_memread_i && ex_rt_i != 5'd0 &&
                 (ex_rt_i == id_rs_i || (id_uses_rt_i && ex_rt_i == id_rt_i));
      branch   = !rst_i && !frozen && mem_branch_taken_i;
      bubble   = !rst_i && !frozen && !mem_branch_taken_i && load_use;
   end
   assign pc_write_o     = !(frozen || bubble);
   assign if_id_write_o  = !(frozen || bubble);
   assign pipe_hold_o    = frozen;
   assign if_id_flush_o  = branch;
   assign id_ex_flush_o  = branch || bubble;
   assign ex_mem_flush_o = branch;
   assign mem_timeout_o  = st_to;
   assign state_o        = state;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_RUN;
         wait_cnt <= '0;
      end else if (st_wait) begin
         if (mem_ready_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
         end else if (wait_cnt == WW'(MEM_TIMEOUT)) state <= ST_TIMEOUT;
         else wait_cnt <= wait_cnt + WW'(1);
      end else if (!st_to) begin
         state    <= frozen ? ST_MEM_WAIT : ST_RUN;
         wait_cnt <= frozen ? WW'(1) : '0;
      end
   end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .inc  (!pc_write_o),
      .cnt  (stall_cnt_o)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .inc  (branch),
      .cnt  (flush_cnt_o)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized run against a cycle-level reference model
module tb_pipe_hazard_ctrl;
   localparam int TO  = 4;
   localparam int CW  = 3;
   localparam int SAT = (1 << CW) - 1;
   logic clk = 1'b0;
   logic rst_i, id_uses_rt_i, ex_memread_i, mem_branch_taken_i, mem_access_i, mem_ready_i;
   logic [4:0] id_rs_i, id_rt_i, ex_rt_i;
   logic pc_write_o, if_id_write_o, pipe_hold_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_timeout_o;
   logic [CW-1:0] stall_cnt_o, flush_cnt_o;
   logic [1:0] state_o;
   logic [5:0] ctrl;
   int total = 0, bad = 0;
   int m_wait, m_stall, m_flush;
   bit m_to, e_fz, e_br, e_rst;
   logic [5:0] e_ctrl;
   logic [1:0] e_state;
   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i),
      .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i), .mem_branch_taken_i(mem_branch_taken_i),
      .mem_access_i(mem_access_i), .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
      .if_id_write_o(if_id_write_o), .pipe_hold_o(pipe_hold_o), .if_id_flush_o(if_id_flush_o),
      .id_ex_flush_o(id_ex_flush_o), .ex_mem_flush_o(ex_mem_flush_o), .mem_timeout_o(mem_timeout_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .state_o(state_o)
   );
   assign ctrl = {pc_write_o, if_id_write_o, pipe_hold_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o};
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end
   // Model: memory freezes the pipe; the (TO+1)-th consecutive frozen cycle ends in a permanent timeout.
   task automatic drive(input bit r, mr, input logic [4:0] ert, rs, rt, input bit ur, br, acc, rdy);
      bit fz, lu, b, bub;
      @(negedge clk);
      rst_i = r; ex_memread_i = mr; ex_rt_i = ert; id_rs_i = rs; id_rt_i = rt;
      id_uses_rt_i = ur; mem_branch_taken_i = br; mem_access_i = acc; mem_ready_i = rdy;
      #1;
      fz  = !r && (m_to || (!rdy && (m_wait > 0 || acc)));
      lu  = mr && ert != 0 && (ert == rs || (ur && ert == rt));
      b   = !r && !fz && br;
      bub = !r && !fz && !br && lu;
      e_ctrl  = {!(fz || bub), !(fz || bub), fz, b, b || bub, b};
      e_fz = fz; e_br = b; e_rst = r;
      e_state = m_to ? 2'd2 : (m_wait > 0 ? 2'd1 : 2'd0);
   endtask
   task automatic tick();
      @(posedge clk);
      if (e_rst) begin
         m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (!e_ctrl[5] && m_stall < SAT) m_stall++;
         if (e_br && m_flush < SAT) m_flush++;
         if (!e_fz) m_wait = 0;
         else if (!m_to) begin
            m_wait++;
            if (m_wait > TO) m_to = 1;
         end
      end
   endtask
   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask
   task automatic do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
   endtask
   task automatic test_reset();
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      total++; if (ctrl !== 6'b110000) begin bad++; $display("FAIL reset_ctrl got=%b exp=110000", ctrl); end
      total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
      total++; if (stall_cnt_o !== 0 || flush_cnt_o !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt_o, flush_cnt_o); end
      total++; if (mem_timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout_o); end
      tick();
   endtask
   task automatic test_load_use();
      do_reset();
      drive(0, 1, 2, 2, 4, 1, 0, 0, 1);
      total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL lu_stall got=%b exp=000010", ctrl); end
      tick();
      drive(0, 0, 0, 2, 4, 1, 0, 0, 1);
      total++; if (ctrl !== 6'b110000) begin bad++; $display("FAIL lu_release got=%b exp=110000", ctrl); end
      total++; if (stall_cnt_o !== 3'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt_o); end
      tick();
   endtask
   task automatic test_no_stall();
      do_reset();
      drive(0, 1, 0, 0, 3, 1, 0, 0, 1);
      total++; if (ctrl !== 6'b110000) begin bad++; $display("FAIL r0_no_stall got=%b exp=110000", ctrl); end
      tick();
      drive(0, 1, 5, 1, 5, 0, 0, 0, 1);
      total++; if (ctrl !== 6'b110000) begin bad++; $display("FAIL rt_unused_no_stall got=%b exp=110000", ctrl); end
      tick();
      drive(0, 1, 5, 1, 5, 1, 0, 0, 1);
      total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL rt_used_stall got=%b exp=000010", ctrl); end
      tick();
   endtask
   task automatic test_branch_hazard();
      do_reset();
      drive(0, 1, 2, 2, 4, 1, 1, 0, 1);
      total++; if (ctrl !== 6'b110111) begin bad++; $display("FAIL br_flush got=%b exp=110111", ctrl); end
      tick();
      idle();
      total++; if (flush_cnt_o !== 3'd1 || stall_cnt_o !== 3'd0) begin bad++; $display("FAIL br_cnt got=%0d/%0d exp=1/0", flush_cnt_o, stall_cnt_o); end
      total++; if (ctrl !== 6'b110000) begin bad++; $display("FAIL br_one_cycle got=%b exp=110000", ctrl); end
      tick();
   endtask
   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total++; if (ctrl !== 6'b001000) begin bad++; $display("FAIL wait_hold_%0d got=%b exp=001000", i, ctrl); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      total++; if (ctrl !== 6'b110000 || state_o !== 2'd1) begin bad++; $display("FAIL wait_release got=%b st=%0d exp=110000 st=1", ctrl, state_o); end
      tick();
      idle();
      total++; if (stall_cnt_o !== 3'd3 || state_o !== 2'd0) begin bad++; $display("FAIL wait_after got=%0d st=%0d exp=3 st=0", stall_cnt_o, state_o); end
      tick();
   endtask
   task automatic test_deferred_branch();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 2, 2, 0, 0, 1, 1, 0);
         total++; if (ctrl !== 6'b001000) begin bad++; $display("FAIL defer_hold_%0d got=%b exp=001000", i, ctrl); end
         tick();
      end
      drive(0, 1, 2, 2, 0, 0, 1, 1, 1);
      total++; if (ctrl !== 6'b110111) begin bad++; $display("FAIL defer_flush got=%b exp=110111", ctrl); end
      tick();
      idle();
      total++; if (flush_cnt_o !== 3'd1 || stall_cnt_o !== 3'd2) begin bad++; $display("FAIL defer_cnt got=%0d/%0d exp=1/2", flush_cnt_o, stall_cnt_o); end
      tick();
   endtask
   task automatic test_timeout();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
         total++; if (ctrl !== 6'b001000 || mem_timeout_o !== 1'b0) begin bad++; $display("FAIL to_wait_%0d got=%b to=%b exp=001000 to=0", i, ctrl, mem_timeout_o); end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 2, 2, 0, 0, 1, 0, 1);
         total++; if (ctrl !== 6'b001000 || mem_timeout_o !== 1'b1 || state_o !== 2'd2) begin bad++; $display("FAIL to_sticky_%0d got=%b to=%b st=%0d exp=001000 to=1 st=2", i, ctrl, mem_timeout_o, state_o); end
         tick();
      end
      idle();
      total++; if (stall_cnt_o !== 3'd7 || flush_cnt_o !== 3'd0) begin bad++; $display("FAIL to_cnt got=%0d/%0d exp=7/0", stall_cnt_o, flush_cnt_o); end
      do_reset();
      idle();
      total++; if (state_o !== 2'd0 || mem_timeout_o !== 1'b0 || stall_cnt_o !== 3'd0 || ctrl !== 6'b110000) begin bad++; $display("FAIL to_reset st=%0d to=%b cnt=%0d ctrl=%b exp 0/0/0/110000", state_o, mem_timeout_o, stall_cnt_o, ctrl); end
      tick();
   endtask
   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 7, 7, 0, 0, 0, 0, 1);
         tick();
         idle();
         tick();
      end
      idle();
      total++; if (stall_cnt_o !== 3'd7) begin bad++; $display("FAIL sat_stall got=%0d exp=7", stall_cnt_o); end
      tick();
   endtask
   task automatic test_random();
      int thr;
      do_reset();
      thr = 6;
      for (int c = 0; c < 600; c++) begin
         if (c % 40 == 0) thr = $urandom_range(0, 7);
         drive($urandom_range(0, 60) == 0, 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) < thr);
         total++; if (ctrl !== e_ctrl) begin bad++; $display("FAIL rnd_ctrl c=%0d got=%b exp=%b", c, ctrl, e_ctrl); end
         total++; if (state_o !== e_state || mem_timeout_o !== 1'(m_to)) begin bad++; $display("FAIL rnd_state c=%0d got=%0d/%b exp=%0d/%b", c, state_o, mem_timeout_o, e_state, m_to); end
         total++; if (stall_cnt_o !== CW'(m_stall) || flush_cnt_o !== CW'(m_flush)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt_o, flush_cnt_o, m_stall, m_flush); end
         tick();
      end
   endtask
   initial begin
      m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_hazard();
      test_mem_wait();
      test_deferred_branch();
      test_timeout();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
